// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - request/response sequencer driving an external combinational 8-bit ALU
//
// Accepts an ALU request over a valid/ready handshake. It holds the operands and opcode in
// registers, optionally feeds the ALU result back as operand A for extra iterations, and returns
// the final result over a valid/ready response handshake.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   req_valid_i  request valid
//   req_ready_o  request ready (IDLE only)
//   req_a_i      operand A
//   req_b_i      operand B
//   req_op_i     ALU opcode
//   req_iter_i   extra iterations (0 = single evaluation)
//   alu_a_o      registered operand A to ALU
//   alu_b_o      registered operand B to ALU
//   alu_op_o     registered opcode to ALU
//   alu_res_i    combinational ALU result
//   rsp_valid_o  response valid (RESP only)
//   rsp_ready_i  response ready
//   rsp_data_o   final result
//   rsp_zero_o   rsp_data_o == 0, registered together with rsp_data_o
//   busy_o       state != IDLE
module alu_sequencer #(
    parameter int ITER_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [7:0]        req_a_i,
    input  logic [7:0]        req_b_i,
    input  logic [2:0]        req_op_i,
    input  logic [ITER_W-1:0] req_iter_i,
    output logic [7:0]        alu_a_o,
    output logic [7:0]        alu_b_o,
    output logic [2:0]        alu_op_o,
    input  logic [7:0]        alu_res_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [7:0]        rsp_data_o,
    output logic              rsp_zero_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ITER_W-1:0] remaining;
    logic              req_fire;
    logic              rsp_fire;
    logic              last_iter;

    // All handshake outputs decode from the state register only.
    assign req_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == RESP);
    assign busy_o      = (state != IDLE);

    assign req_fire  = req_valid_i && (state == IDLE);
    assign rsp_fire  = rsp_ready_i && (state == RESP);
    assign last_iter = (remaining == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_fire) state_next = EXEC;
            EXEC: if (last_iter) state_next = RESP;
            RESP: if (rsp_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand, counter and response registers. Each one changes only on accept or capture,
    // so the last command's values remain visible after it completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_a_o    <= 8'h00;
            alu_b_o    <= 8'h00;
            alu_op_o   <= 3'b000;
            remaining  <= '0;
            rsp_data_o <= 8'h00;
            rsp_zero_o <= 1'b0;
        end else begin
            if (req_fire) begin
                alu_a_o   <= req_a_i;
                alu_b_o   <= req_b_i;
                alu_op_o  <= req_op_i;
                remaining <= req_iter_i;
            end else if (state == EXEC) begin
                if (!last_iter) begin
                    // Feed the result back as A; B and the opcode stay put.
                    alu_a_o   <= alu_res_i;
                    remaining <= remaining - 1'b1;
                end else begin
                    rsp_data_o <= alu_res_i;
                    rsp_zero_o <= (alu_res_i == 8'h00);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_a = 8'h00;
    logic [7:0] req_b = 8'h00;
    logic [2:0] req_op = 3'b000;
    logic [2:0] req_iter = 3'd0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_res;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       rsp_zero;
    logic       busy;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.ITER_W(3)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_op_i    (req_op),
        .req_iter_i  (req_iter),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_op_o    (alu_op),
        .alu_res_i   (alu_res),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_zero_o  (rsp_zero),
        .busy_o      (busy)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a << b[2:0];
            3'd3: return a >> b[2:0];
            3'd4: return a & b;
            3'd5: return a | b;
            3'd6: return a ^ b;
            default: return (a == b) ? 8'h01 : 8'h00;
        endcase
    endfunction

    assign alu_res = alu_f(alu_a, alu_b, alu_op);

    // Reference: apply the operation it+1 times, each time using the previous result as A.
    function automatic logic [7:0] ref_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op, input int it);
        logic [7:0] r;
        r = a;
        for (int i = 0; i <= it; i++) r = alu_f(r, b, op);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge while the DUT is idle; returns at a negedge, idle again.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                          input int it, input int hold, input logic [7:0] exp, input string name);
        int lat;
        rsp_ready = (hold == 0);
        chk({name, " ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_iter  = it[2:0];
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);
        req_op    = 3'($urandom);
        req_iter  = 3'($urandom);
        chk({name, " busy"}, busy, 1);
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({name, " latency"}, lat, it + 2);
        chk({name, " data"}, rsp_data, exp);
        chk({name, " zero"}, rsp_zero, (exp == 8'h00) ? 1 : 0);
        for (int h = 0; h < hold; h++) begin
            cycle();
            chk({name, " held valid"}, rsp_valid, 1);
            chk({name, " held data"}, rsp_data, exp);
        end
        rsp_ready = 1'b1;
        cycle();
        chk({name, " valid drop"}, rsp_valid, 0);
        chk({name, " ready back"}, req_ready, 1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        int         it;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int         seen;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [2:0] rop;
        int         rit;

        vecs[0]  = '{8'h05, 8'h03, 3'd0, 0, 8'h08};
        vecs[1]  = '{8'h00, 8'h01, 3'd1, 0, 8'hFF};
        vecs[2]  = '{8'h01, 8'h01, 3'd0, 3, 8'h05};
        vecs[3]  = '{8'h01, 8'h01, 3'd2, 7, 8'h00};
        vecs[4]  = '{8'h05, 8'h05, 3'd7, 0, 8'h01};
        vecs[5]  = '{8'h03, 8'h03, 3'd7, 1, 8'h00};
        vecs[6]  = '{8'hAA, 8'hFF, 3'd6, 0, 8'h55};
        vecs[7]  = '{8'h80, 8'h01, 3'd3, 2, 8'h10};
        vecs[8]  = '{8'hF0, 8'h3C, 3'd4, 0, 8'h30};
        vecs[9]  = '{8'h0F, 8'hF0, 3'd5, 0, 8'hFF};
        vecs[10] = '{8'h10, 8'h03, 3'd1, 2, 8'h07};
        vecs[11] = '{8'h81, 8'h09, 3'd2, 0, 8'h02};

        // Reset values while reset is held.
        #3;
        chk("rst ready", req_ready, 1);
        chk("rst valid", rsp_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst alu_a", alu_a, 0);
        chk("rst alu_b", alu_b, 0);
        chk("rst alu_op", alu_op, 0);
        chk("rst data", rsp_data, 0);
        chk("rst zero", rsp_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("post-rst ready", req_ready, 1);
        chk("post-rst busy", busy, 0);

        // Table-driven directed vectors.
        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].it, 0, vecs[i].exp, $sformatf("vec%0d", i));

        // Last-value retention after completion (vec11: shl 0x81 by 1).
        chk("keep alu_a", alu_a, 8'h81);
        chk("keep alu_b", alu_b, 8'h09);
        chk("keep alu_op", alu_op, 2);
        chk("keep data", rsp_data, 8'h02);

        // Iterated add: operand A steps through 1,2,3,4.
        req_valid = 1'b1; req_a = 8'h01; req_b = 8'h01; req_op = 3'd0; req_iter = 3'd3;
        cycle();
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("iter alu_a step%0d", k), alu_a, k + 1);
            chk($sformatf("iter valid low%0d", k), rsp_valid, 0);
            cycle();
        end
        chk("iter valid", rsp_valid, 1);
        chk("iter data", rsp_data, 8'h05);
        cycle();

        // Asynchronous reset mid-cycle with non-zero registers.
        #2 rst_n = 1'b0;
        #1;
        chk("async alu_a", alu_a, 0);
        chk("async alu_b", alu_b, 0);
        chk("async data", rsp_data, 0);
        chk("async ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Backpressure: response held while a new request waits.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_a = 8'h20; req_b = 8'h22; req_op = 3'd0; req_iter = 3'd0;
        cycle();
        req_a = 8'h09; req_b = 8'h04; req_op = 3'd1; req_iter = 3'd1;
        cycle();
        chk("bp valid", rsp_valid, 1);
        for (int h = 0; h < 5; h++) begin
            chk("bp data stable", rsp_data, 8'h42);
            chk("bp ready low", req_ready, 0);
            chk("bp alu_a held", alu_a, 8'h20);
            cycle();
        end
        rsp_ready = 1'b1;
        cycle();
        chk("bp idle ready", req_ready, 1);
        chk("bp valid drop", rsp_valid, 0);
        cycle();
        req_valid = 1'b0;
        chk("bp pending taken alu_a", alu_a, 8'h09);
        chk("bp pending busy", busy, 1);
        cycle();
        cycle();
        chk("bp pending valid", rsp_valid, 1);
        chk("bp pending data", rsp_data, 8'h01);
        cycle();

        // Reset in the third EXEC cycle discards the command.
        req_valid = 1'b1; req_a = 8'h01; req_b = 8'h01; req_op = 3'd2; req_iter = 3'd7;
        cycle();
        req_valid = 1'b0;
        cycle();
        cycle();
        chk("mid busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst busy", busy, 0);
        chk("mid rst alu_a", alu_a, 0);
        chk("mid rst ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (rsp_valid) seen++;
        end
        chk("mid no response", seen, 0);
        run_op(8'h02, 8'h02, 3'd0, 0, 0, 8'h04, "after mid rst");

        // Randomized commands with random response backpressure.
        for (int n = 0; n < 40; n++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 3'($urandom);
            rit = $urandom_range(0, 7);
            run_op(ra, rb, rop, rit, $urandom_range(0, 2), ref_model(ra, rb, rop, rit), $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
